// File: rtl/countdown_phase_sequencer_if.sv
// Control and status bundle for countdown_phase_sequencer.
// The master drives the schedule controls; the slave (sequencer) drives count and phase status.
interface countdown_phase_sequencer_if #(
  parameter int W = 4
);
  logic         start_i;
  logic         stop_i;
  logic         pause_i;
  logic         ped_req_i;
  logic [W-1:0] count_o;
  logic [1:0]   phase_o;
  logic         phase_done_o;
  logic         busy_o;

  modport master (
    output start_i, stop_i, pause_i, ped_req_i,
    input  count_o, phase_o, phase_done_o, busy_o
  );

  modport slave (
    input  start_i, stop_i, pause_i, ped_req_i,
    output count_o, phase_o, phase_done_o, busy_o
  );
endinterface

// File: rtl/countdown_phase_sequencer.sv
// Three-phase GREEN/YELLOW/RED scheduler that owns a W-bit down-counter.
// Supports start/stop, pause, and pedestrian-style truncation of GREEN.
module countdown_phase_sequencer #(
  parameter int W          = 4,
  parameter int GREEN_LOAD = 9,
  parameter int YELLOW_LOAD = 1,
  parameter int RED_LOAD   = 5,
  parameter int PED_CAP    = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  countdown_phase_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    RED    = 2'd3
  } phase_e;

  localparam logic [W-1:0] G_LOAD = W'(GREEN_LOAD);
  localparam logic [W-1:0] Y_LOAD = W'(YELLOW_LOAD);
  localparam logic [W-1:0] R_LOAD = W'(RED_LOAD);
  localparam logic [W-1:0] CAP    = W'(PED_CAP);
  localparam logic [W-1:0] ONE    = W'(1);

  phase_e       phase_q;
  logic [W-1:0] count_q;
  logic         done_q;
  logic         busy_q;
  logic         ped_q;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      RED:     return GREEN;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [W-1:0] load_of(input phase_e p);
    case (p)
      GREEN:   return G_LOAD;
      YELLOW:  return Y_LOAD;
      RED:     return R_LOAD;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ped_q  <= ped_q | bus.ped_req_i;
      if (phase_q != IDLE && bus.stop_i) begin
        phase_q <= IDLE;
        count_q <= '0;
        busy_q  <= 1'b0;
        ped_q   <= bus.ped_req_i;
      end else if (phase_q == IDLE) begin
        if (bus.start_i && !bus.stop_i) begin
          phase_q <= GREEN;
          count_q <= G_LOAD;
          busy_q  <= 1'b1;
        end
      end else if (!bus.pause_i) begin
        // A pending request is consumed on the first un-paused GREEN cycle, truncating or not.
        if (phase_q == GREEN) ped_q <= bus.ped_req_i;
        if (phase_q == GREEN && ped_q && count_q > CAP) begin
          count_q <= CAP;
        end else if (count_q != '0) begin
          count_q <= count_q - ONE;
        end else begin
          phase_q <= next_phase(phase_q);
          count_q <= load_of(next_phase(phase_q));
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.count_o      = count_q;
  assign bus.phase_o      = phase_q;
  assign bus.phase_done_o = done_q;
  assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_countdown_phase_sequencer.sv
// Scoreboard bench for countdown_phase_sequencer: directed stimulus queues expected
// post-edge state; an independent monitor pops and compares every cycle.
module tb_countdown_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_phase_sequencer_if #(.W(4)) bus ();

  countdown_phase_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [1:0] ph;
    logic [3:0] cnt;
    logic       dn;
    logic       bz;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a new state after every edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("phase", int'(bus.phase_o), int'(e.ph));
      chk("count", int'(bus.count_o), int'(e.cnt));
      chk("phase_done", int'(bus.phase_done_o), int'(e.dn));
      chk("busy", int'(bus.busy_o), int'(e.bz));
    end
  end

  task automatic cyc(input int st, input int sp, input int pa, input int pr, input int rs,
                     input int ph, input int cnt, input int dn);
    exp_t e;
    @(negedge clk);
    bus.start_i   = st[0];
    bus.stop_i    = sp[0];
    bus.pause_i   = pa[0];
    bus.ped_req_i = pr[0];
    rst           = rs[0];
    e.ph  = ph[1:0];
    e.cnt = cnt[3:0];
    e.dn  = dn[0];
    e.bz  = (ph != 0);
    sb.push_back(e);
  endtask

  task automatic tick(input int ph, input int cnt, input int dn);
    cyc(0, 0, 0, 0, 0, ph, cnt, dn);
  endtask

  task automatic down(input int ph, input int from, input int to);
    for (int c = from; c >= to; c--) tick(ph, c, 0);
  endtask

  initial begin
    bus.start_i   = 1'b0;
    bus.stop_i    = 1'b0;
    bus.pause_i   = 1'b0;
    bus.ped_req_i = 1'b0;

    // Reset state
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);

    // Start and one full 18-cycle loop
    cyc(1, 0, 0, 0, 0, 1, 9, 0);
    down(1, 8, 0);
    tick(2, 1, 1); tick(2, 0, 0);
    tick(3, 5, 1); down(3, 4, 0);
    tick(1, 9, 1);

    // Pause for 4 cycles at GREEN 6
    down(1, 8, 6);
    repeat (4) cyc(0, 0, 1, 0, 0, 1, 6, 0);
    down(1, 5, 0);
    tick(2, 1, 1); tick(2, 0, 0);
    tick(3, 5, 1); down(3, 4, 0);
    tick(1, 9, 1);

    // Request pending at GREEN 7 truncates to 2
    tick(1, 8, 0);
    cyc(0, 0, 0, 1, 0, 1, 7, 0);
    tick(1, 2, 0); tick(1, 1, 0); tick(1, 0, 0);
    tick(2, 1, 1); tick(2, 0, 0);
    tick(3, 5, 1); down(3, 4, 0);
    tick(1, 9, 1);

    // Request pending at GREEN 1: normal decrement
    down(1, 8, 2);
    cyc(0, 0, 0, 1, 0, 1, 1, 0);
    tick(1, 0, 0);
    tick(2, 1, 1); tick(2, 0, 0);

    // Request during RED is held until GREEN
    tick(3, 5, 1); tick(3, 4, 0); tick(3, 3, 0);
    cyc(0, 0, 0, 1, 0, 3, 2, 0);
    tick(3, 1, 0); tick(3, 0, 0);
    tick(1, 9, 1); tick(1, 2, 0); tick(1, 1, 0); tick(1, 0, 0);
    tick(2, 1, 1);

    // Stop during YELLOW, then Start+Stop together
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0);

    // Reset at RED 4 with a pending request, which must be discarded
    cyc(1, 0, 0, 0, 0, 1, 9, 0);
    down(1, 8, 0);
    tick(2, 1, 1); tick(2, 0, 0);
    tick(3, 5, 1);
    cyc(0, 0, 0, 1, 0, 3, 4, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 9, 0);
    down(1, 8, 5);

    // Start while active at Count 5 is ignored
    cyc(1, 0, 0, 0, 0, 1, 4, 0);
    tick(1, 3, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
